div_config_ctrl: RTL and testbench

- Command front-end that programs and gates the frequency divider (`DIV_frecventa`) directly downstream of it.
- Accepts LOAD/START/STOP commands over a valid/ready handshake.
- Drives the divider's DIN_n, CONFIG_DIV and ENABLE inputs with a safe sequence: disable, settle, load, then restore the run state. The divider never sees a divisor change while it is enabled.

---
 rtl/div_config_ctrl.sv | 172 +++++++++++++++++
 tb/tb_div_config_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_config_ctrl.sv
// div_config_ctrl
//   Command front-end for the DIV_frecventa frequency divider. It accepts
//   LOAD/START/STOP/NOP commands over a valid/ready handshake. It drives the
//   divider's DIN_n, CONFIG_DIV and ENABLE inputs so that a divisor is never
//   loaded while the divider is enabled. A load runs this sequence:
//   disable, settle, strobe, one quiet cycle, then restore the run state.
//
// Ports
//   CLK         in   system clock, rising edge
//   RESET       in   asynchronous active-low reset
//   CMD_VALID   in   command present
//   CMD_OP      in   00 NOP, 01 LOAD, 10 START, 11 STOP
//   CMD_DIV     in   divisor for LOAD
//   CMD_READY   out  command accepted on this edge if CMD_VALID is high
//   DIN_N       out  divisor presented to the divider
//   CONFIG_DIV  out  one-cycle load strobe to the divider
//   ENABLE_OUT  out  divider enable
//   RUNNING     out  run flag, restored onto ENABLE_OUT after a load
//   CUR_DIV     out  last divisor actually strobed into the divider
//   BUSY        out  load sequence in progress
//   ERR         out  last accepted command was rejected (LOAD of zero)
module div_config_ctrl #(
  parameter int                 WIDTH           = 32,
  parameter int                 SETTLE_CYCLES   = 2,
  parameter logic [WIDTH-1:0]   DIV_RESET_VALUE = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  input  logic [1:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_DIV,
  output logic             CMD_READY,
  output logic [WIDTH-1:0] DIN_N,
  output logic             CONFIG_DIV,
  output logic             ENABLE_OUT,
  output logic             RUNNING,
  output logic [WIDTH-1:0] CUR_DIV,
  output logic             BUSY,
  output logic             ERR
);

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_START = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUIESCE,
    S_LOAD,
    S_POST
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             cfg_q, cfg_d;
  logic             en_q, en_d;
  logic             run_q, run_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             accept;

  // ready_q is only ever high in IDLE, so it alone qualifies acceptance.
  assign accept = CMD_VALID && ready_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      din_q   <= DIV_RESET_VALUE;
      cfg_q   <= 1'b0;
      en_q    <= 1'b0;
      run_q   <= 1'b0;
      cur_q   <= DIV_RESET_VALUE;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      din_q   <= din_d;
      cfg_q   <= cfg_d;
      en_q    <= en_d;
      run_q   <= run_d;
      cur_q   <= cur_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    din_d   = din_q;
    cfg_d   = 1'b0;
    en_d    = en_q;
    run_d   = run_q;
    cur_d   = cur_q;
    busy_d  = busy_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        // Covers the first edge after reset release as well.
        ready_d = 1'b1;
        if (accept) begin
          err_d = (CMD_OP == OP_LOAD) && (CMD_DIV == '0);
          unique case (CMD_OP)
            OP_START: begin
              run_d = 1'b1;
              en_d  = 1'b1;
            end
            OP_STOP: begin
              run_d = 1'b0;
              en_d  = 1'b0;
            end
            OP_LOAD: begin
              if (CMD_DIV != '0) begin
                din_d   = CMD_DIV;
                en_d    = 1'b0;
                busy_d  = 1'b1;
                ready_d = 1'b0;
                cnt_d   = 8'(SETTLE_CYCLES - 1);
                state_d = S_QUIESCE;
              end
            end
            default: ;
          endcase
        end
      end

      S_QUIESCE: begin
        en_d = 1'b0;
        // Counter starts at SETTLE_CYCLES-1, so QUIESCE lasts SETTLE_CYCLES.
        if (cnt_q == 8'd0) begin
          state_d = S_LOAD;
          cfg_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_LOAD: begin
        cur_d   = din_q;
        state_d = S_POST;
      end

      S_POST: begin
        en_d    = run_q;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign CMD_READY  = ready_q;
  assign DIN_N      = din_q;
  assign CONFIG_DIV = cfg_q;
  assign ENABLE_OUT = en_q;
  assign RUNNING    = run_q;
  assign CUR_DIV    = cur_q;
  assign BUSY       = busy_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_div_config_ctrl.sv
// tb_div_config_ctrl
//   Testbench for div_config_ctrl (WIDTH=32, SETTLE_CYCLES=2). It has
//   three phases:
//   - a cycle-by-cycle vector table for the main load, error, held-command
//     and back-to-back load cases;
//   - a hand-written reset-during-QUIESCE sequence;
//   - a randomized phase checked against a timeline reference model.
//   The model tracks the time since a load was accepted and derives each
//   output from that time.
module tb_div_config_ctrl;

  localparam int W = 32;
  localparam int S = 2;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         CMD_VALID;
  logic [1:0]   CMD_OP;
  logic [W-1:0] CMD_DIV;
  logic         CMD_READY;
  logic [W-1:0] DIN_N;
  logic         CONFIG_DIV;
  logic         ENABLE_OUT;
  logic         RUNNING;
  logic [W-1:0] CUR_DIV;
  logic         BUSY;
  logic         ERR;

  div_config_ctrl #(
    .WIDTH(W),
    .SETTLE_CYCLES(S),
    .DIV_RESET_VALUE(32'd1)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .CMD_VALID(CMD_VALID),
    .CMD_OP(CMD_OP),
    .CMD_DIV(CMD_DIV),
    .CMD_READY(CMD_READY),
    .DIN_N(DIN_N),
    .CONFIG_DIV(CONFIG_DIV),
    .ENABLE_OUT(ENABLE_OUT),
    .RUNNING(RUNNING),
    .CUR_DIV(CUR_DIV),
    .BUSY(BUSY),
    .ERR(ERR)
  );

  initial forever #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic en, input logic cfg,
                         input logic busy, input logic err, input logic run,
                         input logic [31:0] cur, input logic [31:0] din);
    chk({tag, ".ready"},  32'(CMD_READY),  32'(rdy));
    chk({tag, ".enable"}, 32'(ENABLE_OUT), 32'(en));
    chk({tag, ".config"}, 32'(CONFIG_DIV), 32'(cfg));
    chk({tag, ".busy"},   32'(BUSY),       32'(busy));
    chk({tag, ".err"},    32'(ERR),        32'(err));
    chk({tag, ".running"},32'(RUNNING),    32'(run));
    chk({tag, ".cur_div"},CUR_DIV,         cur);
    chk({tag, ".din_n"},  DIN_N,           din);
  endtask

  task automatic set_cmd(input logic v, input logic [1:0] op, input logic [31:0] dv);
    CMD_VALID = v;
    CMD_OP    = op;
    CMD_DIV   = dv;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic [31:0] dv;
    logic        rdy, en, cfg, busy, err, run;
    logic [31:0] cur, din;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(input logic v, input logic [1:0] op, input logic [31:0] dv,
                              input logic rdy, input logic en, input logic cfg, input logic busy,
                              input logic err, input logic run, input logic [31:0] cur,
                              input logic [31:0] din);
    vec_t r;
    r.v = v; r.op = op; r.dv = dv;
    r.rdy = rdy; r.en = en; r.cfg = cfg; r.busy = busy; r.err = err; r.run = run;
    r.cur = cur; r.din = din;
    return r;
  endfunction

  // ---------------- reference model ----------------
  // m_t = edges since a nonzero LOAD was accepted (0 = no sequence).
  // The strobe occupies the cycle at t=S+1. CUR_DIV takes the new divisor at
  // t=S+2. The controller is ready again at t=S+3.
  int          m_t;
  bit          m_ready, m_running, m_err;
  logic [31:0] m_cur, m_din;

  task automatic model_reset();
    m_t = 0; m_ready = 0; m_running = 0; m_err = 0; m_cur = 1; m_din = 1;
  endtask

  task automatic model_edge(input logic v, input logic [1:0] op, input logic [31:0] dv);
    bit acc;
    acc = v && m_ready;
    if (m_t > 0) m_t++;
    if (m_t == S + 2) m_cur = m_din;
    if (m_t == S + 3) m_t = 0;
    if (acc) begin
      m_err = (op == 2'd1) && (dv == 0);
      if (op == 2'd2) m_running = 1;
      if (op == 2'd3) m_running = 0;
      if (op == 2'd1 && dv != 0) begin
        m_din = dv;
        m_t   = 1;
      end
      $display("t=%0t accept op=%0d div=%0d", $time, op, dv);
    end
    m_ready = (m_t == 0);
  endtask

  task automatic model_check(input string tag);
    chk_all(tag, m_ready, (m_t == 0) && m_running, m_t == S + 1, m_t != 0,
            m_err, m_running, m_cur, m_din);
    chk({tag, ".inv_cfg_en"}, 32'(CONFIG_DIV && ENABLE_OUT), 32'd0);
  endtask

  task automatic step(input logic v, input logic [1:0] op, input logic [31:0] dv, input string tag);
    set_cmd(v, op, dv);
    @(posedge CLK);
    if (RESET) model_edge(v, op, dv);
    #1;
    model_check(tag);
  endtask

  initial begin
    // rows: v, op, div | ready, en, cfg, busy, err, run, cur, din
    tbl[0]  = mk(1, 2, 0, 1, 1, 0, 0, 0, 1, 1, 1);
    tbl[1]  = mk(1, 1, 5, 0, 0, 0, 1, 0, 1, 1, 5);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 5);
    tbl[3]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 5);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 5, 5);
    tbl[5]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 5, 5);
    tbl[6]  = mk(1, 1, 0, 1, 1, 0, 0, 1, 1, 5, 5);
    tbl[7]  = mk(0, 0, 0, 1, 1, 0, 0, 1, 1, 5, 5);
    tbl[8]  = mk(1, 2, 0, 1, 1, 0, 0, 0, 1, 5, 5);
    tbl[9]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 5, 5);
    tbl[10] = mk(1, 1, 7, 0, 0, 0, 1, 0, 0, 5, 7);
    tbl[11] = mk(1, 3, 0, 0, 0, 0, 1, 0, 0, 5, 7);
    tbl[12] = mk(1, 3, 0, 0, 0, 1, 1, 0, 0, 5, 7);
    tbl[13] = mk(1, 3, 0, 0, 0, 0, 1, 0, 0, 7, 7);
    tbl[14] = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 7, 7);
    tbl[15] = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 7, 7);
    tbl[16] = mk(1, 1, 3, 0, 0, 0, 1, 0, 0, 7, 3);
    tbl[17] = mk(1, 1, 4, 0, 0, 0, 1, 0, 0, 7, 3);
    tbl[18] = mk(1, 1, 4, 0, 0, 1, 1, 0, 0, 7, 3);
    tbl[19] = mk(1, 1, 4, 0, 0, 0, 1, 0, 0, 3, 3);
    tbl[20] = mk(1, 1, 4, 1, 0, 0, 0, 0, 0, 3, 3);
    tbl[21] = mk(1, 1, 4, 0, 0, 0, 1, 0, 0, 3, 4);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 4);
    tbl[23] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 3, 4);
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4, 4);
    tbl[25] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 4, 4);

    // Reset state and first ready edge.
    RESET = 1'b0;
    set_cmd(0, 0, 0);
    repeat (3) @(posedge CLK);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 1, 1);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk_all("release", 1, 0, 0, 0, 0, 0, 1, 1);
    $display("t=%0t reset released, ready=%0d", $time, CMD_READY);

    // Table phase.
    for (int i = 0; i < 26; i++) begin
      set_cmd(tbl[i].v, tbl[i].op, tbl[i].dv);
      @(posedge CLK);
      #1;
      chk_all($sformatf("row%0d", i), tbl[i].rdy, tbl[i].en, tbl[i].cfg, tbl[i].busy,
              tbl[i].err, tbl[i].run, tbl[i].cur, tbl[i].din);
      $display("t=%0t row %0d v=%0d op=%0d div=%0d -> ready=%0d en=%0d cfg=%0d busy=%0d cur=%0d din=%0d",
               $time, i, tbl[i].v, tbl[i].op, tbl[i].dv, CMD_READY, ENABLE_OUT, CONFIG_DIV,
               BUSY, CUR_DIV, DIN_N);
    end

    // Reset during QUIESCE of LOAD 9.
    set_cmd(1, 1, 9);
    @(posedge CLK);
    #1;
    set_cmd(0, 0, 0);
    chk("rst_mid.busy_before", 32'(BUSY), 32'd1);
    RESET = 1'b0;
    #1;
    chk_all("rst_mid", 0, 0, 0, 0, 0, 0, 1, 1);
    $display("t=%0t reset asserted during quiesce", $time);
    @(posedge CLK);
    #1;
    chk("rst_hold.ready", 32'(CMD_READY), 32'd0);
    RESET = 1'b1;
    model_reset();
    step(1, 1, 9, "reload0");
    for (int i = 1; i < 8; i++) step(i == 1, 2'd1, 32'd9, $sformatf("reload%0d", i));
    chk("reload.cur_div", CUR_DIV, 32'd9);

    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        RESET = 1'b0;
        #1;
        model_reset();
        model_check($sformatf("rnd%0d_rst", i));
        $display("t=%0t random reset", $time);
        step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 32'($urandom_range(0, 6)),
             $sformatf("rnd%0d_hold", i));
        RESET = 1'b1;
      end else begin
        step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 32'($urandom_range(0, 6)),
             $sformatf("rnd%0d", i));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
